// File: rtl/al_bky_pkg.sv
// Shared types and defaults for the Buckeye auto-load flash fetcher.
package al_bky_pkg;

   localparam int unsigned NWORDS_DEF    = 18;
   localparam logic [22:0] BASE_ADDR_DEF = 23'h7E0000;
   // The loader shifts at 1 MHz, so the DONE wait counts in 256-cycle ticks.
   localparam int unsigned TO_PRESCALE_W = 8;

   typedef enum logic [3:0] {
      StIdle,
      StClr,
      StReq,
      StWaitAck,
      StCapt,
      StNext,
      StWaitDone,
      StFinish,
      StError,
      StPlay
   } al_state_e;

endpackage

// File: rtl/al_bky_prefetch_buf.sv
// Image buffer for prefetch mode: words are stored during fetch, then replayed
// to the loader FIFO on consecutive cycles.
module al_bky_prefetch_buf
   import al_bky_pkg::*;
#(
   parameter int unsigned NWORDS = NWORDS_DEF
) (
   input  logic        CLK40,
   input  logic        RST,
   input  logic        clr,
   input  logic        wr_en,
   input  logic [4:0]  wr_idx,
   input  logic [15:0] wr_data,
   input  logic        play_en,
   output logic        play_last,
   output logic        capture,
   output logic [15:0] word,
   output logic [4:0]  play_cnt
);

   localparam logic [4:0] NW5 = 5'(NWORDS);

   logic [15:0] mem [NWORDS];
   logic [4:0]  cnt_q;
   logic        cap_q;
   logic [15:0] word_q;

   always_ff @(posedge CLK40) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   always_ff @(posedge CLK40 or posedge RST) begin
      if (RST) begin
         cnt_q  <= '0;
         cap_q  <= 1'b0;
         word_q <= '0;
      end else begin
         cap_q <= play_en;
         if (clr) begin
            cnt_q <= '0;
         end else if (play_en) begin
            cnt_q  <= cnt_q + 5'd1;
            word_q <= mem[cnt_q];
         end
      end
   end

   assign play_last = play_en && (cnt_q == NW5 - 5'd1);
   assign capture   = cap_q;
   assign word      = word_q;
   assign play_cnt  = cnt_q;

endmodule

// File: rtl/al_bky_flash_fetch.sv
// Reads the Buckeye shift-register image from BPI flash and feeds the loader FIFO.
// Define AL_PREFETCH_EN to buffer the whole image and replay it back-to-back.
module al_bky_flash_fetch
   import al_bky_pkg::*;
#(
   parameter int unsigned       NWORDS    = NWORDS_DEF,
   parameter int unsigned       ADDR_W    = 23,
   parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_ADDR_DEF),
   parameter int unsigned       TO_W      = 12
) (
   input  logic              CLK40,
   input  logic              RST,
   input  logic              START,
   input  logic              BPI_BUSY,
   output logic              BPI_RD_REQ,
   output logic [ADDR_W-1:0] BPI_RD_ADDR,
   input  logic              BPI_RD_ACK,
   input  logic [15:0]       BPI_RD_DATA,
   output logic [15:0]       BPI_AL_REG,
   output logic              CAPTURE,
   input  logic              AL_DONE,
   output logic              CLR_AL_DONE,
   output logic              BUSY,
   output logic              COMPLETE,
   output logic              TIMEOUT_ERR,
   output logic [4:0]        WORD_CNT
);

   localparam logic [4:0] NW5 = 5'(NWORDS);

   al_state_e                state_q, state_d;
   logic [TO_W-1:0]          timer_q, timer_d;
   logic [TO_PRESCALE_W-1:0] pre_q, pre_d;
   logic [ADDR_W-1:0]        addr_q, addr_d;
   logic [4:0]               cnt_q, cnt_d;
   logic                     complete_q, complete_d;
   logic                     to_err_q, to_err_d;
   logic                     armed_q;
   logic                     start_ok, expired, tick;

   // armed_q blocks a START seen on the first edge after reset release.
   assign start_ok = START & armed_q;
   assign expired  = &timer_q;
   assign tick     = (state_q != StWaitDone) || (&pre_q);

`ifdef AL_PREFETCH_EN
   logic buf_wr, play_clr, play_last;
`endif

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      complete_d = complete_q;
      to_err_d   = to_err_q;
`ifdef AL_PREFETCH_EN
      buf_wr     = 1'b0;
      play_clr   = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (start_ok) begin
               state_d    = StClr;
               complete_d = 1'b0;
               to_err_d   = 1'b0;
               cnt_d      = '0;
               addr_d     = BASE_ADDR;
`ifdef AL_PREFETCH_EN
               play_clr   = 1'b1;
`endif
            end
         end
         StClr: state_d = StReq;
         StReq: begin
            if (!BPI_BUSY) state_d = StWaitAck;
            else if (expired) state_d = StError;
         end
         StWaitAck: begin
            if (BPI_RD_ACK) begin
`ifdef AL_PREFETCH_EN
               buf_wr  = 1'b1;
               state_d = StNext;
`else
               state_d = StCapt;
`endif
            end else if (expired) begin
               state_d = StError;
            end
         end
         StCapt: state_d = StNext;
         StNext: begin
            cnt_d  = cnt_q + 5'd1;
            addr_d = addr_q + 1'b1;
            if (cnt_d == NW5) begin
`ifdef AL_PREFETCH_EN
               state_d = StPlay;
`else
               state_d = StWaitDone;
`endif
            end else begin
               state_d = StReq;
            end
         end
`ifdef AL_PREFETCH_EN
         StPlay: if (play_last) state_d = StWaitDone;
`endif
         StWaitDone: begin
            if (AL_DONE) state_d = StFinish;
            else if (expired) state_d = StError;
         end
         StFinish: begin
            complete_d = 1'b1;
            state_d    = StIdle;
         end
         StError: begin
            to_err_d = 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase

      pre_d   = pre_q + 1'b1;
      timer_d = timer_q;
      if (state_d != state_q) begin
         timer_d = '0;
         pre_d   = '0;
      end else if (tick && !expired) begin
         timer_d = timer_q + 1'b1;
      end
   end

   always_ff @(posedge CLK40 or posedge RST) begin
      if (RST) begin
         state_q    <= StIdle;
         timer_q    <= '0;
         pre_q      <= '0;
         addr_q     <= BASE_ADDR;
         cnt_q      <= '0;
         complete_q <= 1'b0;
         to_err_q   <= 1'b0;
         armed_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         pre_q      <= pre_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         complete_q <= complete_d;
         to_err_q   <= to_err_d;
         armed_q    <= 1'b1;
      end
   end

   assign BPI_RD_REQ  = (state_q == StWaitAck);
   assign BPI_RD_ADDR = addr_q;
   assign CLR_AL_DONE = (state_q == StClr);
   assign BUSY        = (state_q != StIdle);
   assign COMPLETE    = complete_q;
   assign TIMEOUT_ERR = to_err_q;

`ifdef AL_PREFETCH_EN
   al_bky_prefetch_buf #(
      .NWORDS (NWORDS)
   ) u_buf (
      .CLK40     (CLK40),
      .RST       (RST),
      .clr       (play_clr),
      .wr_en     (buf_wr),
      .wr_idx    (cnt_q),
      .wr_data   (BPI_RD_DATA),
      .play_en   (state_q == StPlay),
      .play_last (play_last),
      .capture   (CAPTURE),
      .word      (BPI_AL_REG),
      .play_cnt  (WORD_CNT)
   );
`else
   logic [15:0] al_reg_q;

   always_ff @(posedge CLK40 or posedge RST) begin
      if (RST) begin
         al_reg_q <= '0;
      end else if (state_q == StWaitAck && BPI_RD_ACK) begin
         al_reg_q <= BPI_RD_DATA;
      end
   end

   assign BPI_AL_REG = al_reg_q;
   assign CAPTURE    = (state_q == StCapt);
   assign WORD_CNT   = cnt_q;
`endif

endmodule

// File: tb/tb_al_bky_flash_fetch.sv
// Self-checking bench for al_bky_flash_fetch with BPI flash and loader models.
`timescale 1ns/1ps
module tb_al_bky_flash_fetch;

   localparam int          NW   = 18;
   localparam logic [22:0] BASE = 23'h7E0000;

   logic        CLK40 = 1'b0;
   logic        RST, START, BPI_BUSY, BPI_RD_REQ, BPI_RD_ACK;
   logic [22:0] BPI_RD_ADDR;
   logic [15:0] BPI_RD_DATA, BPI_AL_REG;
   logic        CAPTURE, AL_DONE, CLR_AL_DONE, BUSY, COMPLETE, TIMEOUT_ERR;
   logic [4:0]  WORD_CNT;

   int checks = 0, errors = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_w;
   int  req_num = 0, cap_cnt = 0, clr_cnt = 0, withhold = -1, req_age = 0;
   int  done_delay = 50, done_timer = 0, cyc = 0, req_run = 0, last_req_run = 0;
   int  first_cap_cyc = 0, last_cap_cyc = 0, last_ack_cyc = 0;
   bit  inject_ack = 1'b0, clr_pend = 1'b0;

   always #12.5 CLK40 = ~CLK40;

   al_bky_flash_fetch dut (
      .CLK40       (CLK40),
      .RST         (RST),
      .START       (START),
      .BPI_BUSY    (BPI_BUSY),
      .BPI_RD_REQ  (BPI_RD_REQ),
      .BPI_RD_ADDR (BPI_RD_ADDR),
      .BPI_RD_ACK  (BPI_RD_ACK),
      .BPI_RD_DATA (BPI_RD_DATA),
      .BPI_AL_REG  (BPI_AL_REG),
      .CAPTURE     (CAPTURE),
      .AL_DONE     (AL_DONE),
      .CLR_AL_DONE (CLR_AL_DONE),
      .BUSY        (BUSY),
      .COMPLETE    (COMPLETE),
      .TIMEOUT_ERR (TIMEOUT_ERR),
      .WORD_CNT    (WORD_CNT)
   );

   // BPI flash: ACK five cycles into each request, data A000+word index.
   initial begin
      BPI_RD_ACK  = 1'b0;
      BPI_RD_DATA = '0;
      forever begin
         @(negedge CLK40);
         BPI_RD_ACK = 1'b0;
         if (inject_ack) begin
            BPI_RD_ACK  = 1'b1;
            BPI_RD_DATA = 16'hDEAD;
            inject_ack  = 1'b0;
         end else if (BPI_RD_REQ === 1'b1) begin
            req_age++;
            if (req_age == 5 && req_num != withhold) begin
               checks++;
               if (BPI_RD_ADDR !== BASE + 23'(req_num)) begin
                  errors++;
                  $display("FAIL rd_addr word %0d: got %h expected %h", req_num, BPI_RD_ADDR,
                           BASE + 23'(req_num));
               end
               BPI_RD_DATA = 16'hA000 + 16'(req_num);
               BPI_RD_ACK  = 1'b1;
               exp_q.push_back(BPI_RD_DATA);
               req_num++;
               last_ack_cyc = cyc;
            end
         end else begin
            req_age = 0;
         end
      end
   end

   // Capture scoreboard and loader model (DONE cleared one cycle after CLR_AL_DONE).
   initial begin
      AL_DONE = 1'b0;
      forever begin
         @(negedge CLK40);
         cyc++;
         if (BPI_RD_REQ === 1'b1) req_run++;
         else if (req_run != 0) begin
            last_req_run = req_run;
            req_run = 0;
         end
         if (clr_pend) begin
            AL_DONE  = 1'b0;
            clr_pend = 1'b0;
         end
         if (CLR_AL_DONE === 1'b1) begin
            clr_cnt++;
            clr_pend = 1'b1;
         end
         if (CAPTURE === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL capture_unexpected: got data %h expected no CAPTURE", BPI_AL_REG);
            end else begin
               exp_w = exp_q.pop_front();
               if (BPI_AL_REG !== exp_w) begin
                  errors++;
                  $display("FAIL capture_data: got %h expected %h", BPI_AL_REG, exp_w);
               end
            end
            if (cap_cnt == 0) first_cap_cyc = cyc;
            last_cap_cyc = cyc;
            cap_cnt++;
            if (cap_cnt == NW) done_timer = done_delay;
         end else if (done_timer > 0) begin
            done_timer--;
            if (done_timer == 0) AL_DONE = 1'b1;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK40);
   endtask

   task automatic new_run(input int delay);
      req_num = 0; cap_cnt = 0; clr_cnt = 0; done_timer = 0;
      done_delay = delay; withhold = -1;
      exp_q.delete();
   endtask

   task automatic pulse_start;
      START = 1'b1;
      @(negedge CLK40);
      START = 1'b0;
   endtask

   task automatic wait_idle(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge CLK40);
         if (BUSY === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      RST = 1'b1; START = 1'b0; BPI_BUSY = 1'b0;
      tick(3);
      checks++;
      if ({BPI_RD_REQ, CAPTURE, CLR_AL_DONE, BUSY, COMPLETE, TIMEOUT_ERR} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 000000",
                  {BPI_RD_REQ, CAPTURE, CLR_AL_DONE, BUSY, COMPLETE, TIMEOUT_ERR});
      end
      checks++;
      if (BPI_RD_ADDR !== BASE) begin
         errors++; $display("FAIL reset_addr: got %h expected %h", BPI_RD_ADDR, BASE);
      end
      checks++;
      if (WORD_CNT !== 5'd0) begin
         errors++; $display("FAIL reset_word_cnt: got %0d expected 0", WORD_CNT);
      end
      checks++;
      if (BPI_AL_REG !== 16'h0) begin
         errors++; $display("FAIL reset_al_reg: got %h expected 0000", BPI_AL_REG);
      end
      // START held across reset release must be ignored.
      START = 1'b1;
      RST   = 1'b0;
      tick(1);
      START = 1'b0;
      tick(2);
      checks++;
      if (BUSY !== 1'b0) begin
         errors++; $display("FAIL start_at_reset_release: got BUSY=%b expected 0", BUSY);
      end
   endtask

   task automatic test_nominal;
      bit ok;
      new_run(12000);  // 300 us at 40 MHz
      pulse_start();
      wait_idle(20000, ok);
      checks++;
      if (!ok || cap_cnt != NW || clr_cnt != 1) begin
         errors++;
         $display("FAIL nominal_counts: got idle=%0d caps=%0d clr=%0d expected 1/%0d/1",
                  ok, cap_cnt, clr_cnt, NW);
      end
      checks++;
      if (COMPLETE !== 1'b1 || TIMEOUT_ERR !== 1'b0 || WORD_CNT !== 5'(NW)) begin
         errors++;
         $display("FAIL nominal_status: got complete=%b to=%b cnt=%0d expected 1/0/%0d",
                  COMPLETE, TIMEOUT_ERR, WORD_CNT, NW);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL nominal_pending: got %0d words expected 0", exp_q.size());
      end
   endtask

   task automatic test_ack_timeout;
      bit ok;
      new_run(50);
      withhold = 6;
      pulse_start();
      wait_idle(6000, ok);
      checks++;
      if (!ok || TIMEOUT_ERR !== 1'b1 || COMPLETE !== 1'b0 || BPI_RD_REQ !== 1'b0) begin
         errors++;
         $display("FAIL ack_timeout_flags: got idle=%0d to=%b complete=%b req=%b expected 1/1/0/0",
                  ok, TIMEOUT_ERR, COMPLETE, BPI_RD_REQ);
      end
      checks++;
      if (WORD_CNT !== 5'd6 || cap_cnt != 6) begin
         errors++;
         $display("FAIL ack_timeout_count: got cnt=%0d caps=%0d expected 6/6", WORD_CNT, cap_cnt);
      end
      checks++;
      if (last_req_run < 4095 || last_req_run > 4097) begin
         errors++;
         $display("FAIL ack_timeout_len: got %0d cycles expected 4095..4097", last_req_run);
      end
      new_run(50);
      pulse_start();
      checks++;
      if (TIMEOUT_ERR !== 1'b0) begin
         errors++; $display("FAIL restart_clears_err: got %b expected 0", TIMEOUT_ERR);
      end
      wait_idle(3000, ok);
      checks++;
      if (!ok || COMPLETE !== 1'b1 || cap_cnt != NW) begin
         errors++;
         $display("FAIL restart_run: got complete=%b caps=%0d expected 1/%0d", COMPLETE, cap_cnt,
                  NW);
      end
   endtask

   task automatic test_bpi_busy;
      bit ok;
      int reqs;
      new_run(50);
      BPI_BUSY = 1'b1;
      pulse_start();
      reqs = 0;
      repeat (100) begin
         @(negedge CLK40);
         if (BPI_RD_REQ === 1'b1) reqs++;
      end
      checks++;
      if (reqs != 0) begin
         errors++; $display("FAIL busy_no_req: got %0d REQ cycles expected 0", reqs);
      end
      BPI_BUSY = 1'b0;
      wait_idle(3000, ok);
      checks++;
      if (!ok || COMPLETE !== 1'b1 || cap_cnt != NW) begin
         errors++;
         $display("FAIL busy_run: got complete=%b caps=%0d expected 1/%0d", COMPLETE, cap_cnt, NW);
      end
   endtask

   task automatic test_spurious;
      bit ok;
      new_run(50);
      inject_ack = 1'b1;
      tick(5);
      checks++;
      if (cap_cnt != 0 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL stray_ack: got caps=%0d busy=%b expected 0/0", cap_cnt, BUSY);
      end
      pulse_start();
      for (int i = 0; i < 500 && req_num < 2; i++) tick(1);
      pulse_start();
      wait_idle(3000, ok);
      checks++;
      if (!ok || clr_cnt != 1 || cap_cnt != NW || COMPLETE !== 1'b1) begin
         errors++;
         $display("FAIL start_while_busy: got clr=%0d caps=%0d complete=%b expected 1/%0d/1",
                  clr_cnt, cap_cnt, COMPLETE, NW);
      end
   endtask

   task automatic test_stale_done;
      bit ok;
      new_run(500);
      AL_DONE = 1'b1;
      tick(2);
      pulse_start();
      for (int i = 0; i < 2000 && cap_cnt < NW; i++) tick(1);
      tick(100);
      checks++;
      if (BUSY !== 1'b1 || COMPLETE !== 1'b0 || clr_cnt != 1) begin
         errors++;
         $display("FAIL stale_done: got busy=%b complete=%b clr=%0d expected 1/0/1",
                  BUSY, COMPLETE, clr_cnt);
      end
      wait_idle(2000, ok);
      checks++;
      if (!ok || COMPLETE !== 1'b1) begin
         errors++; $display("FAIL stale_done_finish: got complete=%b expected 1", COMPLETE);
      end
   endtask

   task automatic test_mid_reset;
      new_run(50);
      pulse_start();
      for (int i = 0; i < 2000 && cap_cnt < 10; i++) tick(1);
      @(posedge CLK40);
      #2 RST = 1'b1;
      #1;
      checks++;
      if ({BPI_RD_REQ, CAPTURE, CLR_AL_DONE, BUSY} !== 4'b0 || WORD_CNT !== 5'd0 ||
          BPI_RD_ADDR !== BASE || BPI_AL_REG !== 16'h0) begin
         errors++;
         $display("FAIL mid_reset: got flags=%b cnt=%0d addr=%h reg=%h expected 0/0/%h/0000",
                  {BPI_RD_REQ, CAPTURE, CLR_AL_DONE, BUSY}, WORD_CNT, BPI_RD_ADDR, BPI_AL_REG,
                  BASE);
      end
      @(negedge CLK40);
      RST = 1'b0;
      new_run(50);
      tick(50);
      checks++;
      if (cap_cnt != 0 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL after_reset_quiet: got caps=%0d busy=%b expected 0/0", cap_cnt, BUSY);
      end
   endtask

`ifdef AL_PREFETCH_EN
   task automatic test_prefetch;
      bit ok;
      new_run(50);
      pulse_start();
      wait_idle(3000, ok);
      checks++;
      if (!ok || cap_cnt != NW || last_cap_cyc - first_cap_cyc != NW - 1 ||
          first_cap_cyc <= last_ack_cyc) begin
         errors++;
         $display("FAIL prefetch_burst: got caps=%0d span=%0d first=%0d lastack=%0d expected %0d/%0d",
                  cap_cnt, last_cap_cyc - first_cap_cyc, first_cap_cyc, last_ack_cyc, NW, NW - 1);
      end
      checks++;
      if (COMPLETE !== 1'b1 || WORD_CNT !== 5'(NW)) begin
         errors++;
         $display("FAIL prefetch_status: got complete=%b cnt=%0d expected 1/%0d", COMPLETE,
                  WORD_CNT, NW);
      end
      new_run(50);
      withhold = 4;
      pulse_start();
      wait_idle(6000, ok);
      checks++;
      if (!ok || cap_cnt != 0 || TIMEOUT_ERR !== 1'b1) begin
         errors++;
         $display("FAIL prefetch_timeout: got caps=%0d to=%b expected 0/1", cap_cnt, TIMEOUT_ERR);
      end
   endtask
`endif

   initial begin
      RST = 1'b1; START = 1'b0; BPI_BUSY = 1'b0;
      test_reset();
      test_nominal();
`ifdef AL_PREFETCH_EN
      test_prefetch();
`else
      test_ack_timeout();
      test_bpi_busy();
      test_spurious();
      test_stale_done();
      test_mid_reset();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
